// File: rtl/mpsoc_mpram_master.sv
// Request-side controller for the single-port MPSoC RAM: valid/ready request channel to
// active-low RAM strobes, with read data returned through a 2-entry response buffer.
// Optional power-up zero sweep of the whole array is enabled by defining MPRAM_INIT_EN.
module mpsoc_mpram_master #(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MEM_SIZE = 256
) (
    input  logic          ram_clk,
    input  logic          ram_rstn,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_be,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,

    output logic          init_done,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_cen,
    output logic [1:0]    ram_wen,
    input  logic [DW-1:0] ram_dout
);

    localparam int NUM_LANES = DW / 8;

    generate
        if ((DW != 16) || (MEM_SIZE < (2**AW) * NUM_LANES)) begin : g_cfg_chk
            $error("mpsoc_mpram_master: DW must be 16 and MEM_SIZE must cover 2**AW words");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

`ifdef MPRAM_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
`else
    localparam state_t RST_STATE = ST_BOOT;
`endif

    state_t          state_q, state_d;
    logic            run;
    logic            in_init;
    logic [AW-1:0]   init_addr;

    logic [DW-1:0]   fifo_mem [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      cnt_q;
    logic            rd_inflight_q;
    logic [1:0]      pending;

    logic            pop, push;
    logic            acc, rd_fire, wr_fire;
    logic [NUM_LANES-1:0] lane_wen;

    logic            ram_cen_c;
    logic [1:0]      ram_wen_c;
    logic [AW-1:0]   ram_addr_c, addr_q;
    logic [DW-1:0]   ram_din_c, din_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn) state_q <= RST_STATE;
        else           state_q <= state_d;
    end

`ifdef MPRAM_INIT_EN
    logic [AW-1:0] init_cnt_q;

    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn)                init_cnt_q <= '0;
        else if (state_q == ST_INIT)  init_cnt_q <= init_cnt_q + 1'b1;
    end

    assign in_init   = (state_q == ST_INIT);
    assign init_addr = init_cnt_q;
    assign init_done = (state_q == ST_RUN);
`else
    assign in_init   = 1'b0;
    assign init_addr = '0;
    assign init_done = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
`ifdef MPRAM_INIT_EN
            ST_INIT: if (&init_cnt_q) state_d = ST_RUN;
`else
            ST_INIT: state_d = ST_RUN;
`endif
            ST_RUN:  state_d = ST_RUN;
            default: state_d = RST_STATE;
        endcase
    end

    assign run = (state_q == ST_RUN);

    // ---------------------------------------------------------------- accept
    // pending covers the read on the RAM output this cycle plus buffered words,
    // so the buffer can never be asked to hold a third entry.
    assign pending   = cnt_q + {1'b0, rd_inflight_q};
    assign rsp_valid = (cnt_q != 2'd0);
    assign pop       = rsp_valid & rsp_ready;
    assign req_ready = run & ((pending < 2'd2) | pop);
    assign acc       = req_valid & req_ready;
    assign rd_fire   = acc & ~req_we;
    assign wr_fire   = acc & req_we & (|req_be);
    assign push      = rd_inflight_q;

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            assign lane_wen[l] = ~(wr_fire & req_be[l]);
        end
    endgenerate

    // ---------------------------------------------------------------- RAM strobes
    always_comb begin
        ram_cen_c  = 1'b1;
        ram_wen_c  = 2'b11;
        ram_addr_c = addr_q;
        ram_din_c  = din_q;
        if (in_init) begin
            ram_cen_c  = 1'b0;
            ram_wen_c  = 2'b00;
            ram_addr_c = init_addr;
            ram_din_c  = '0;
        end else if (rd_fire) begin
            ram_cen_c  = 1'b0;
            ram_addr_c = req_addr;
        end else if (wr_fire) begin
            ram_cen_c  = 1'b0;
            ram_wen_c  = lane_wen;
            ram_addr_c = req_addr;
            ram_din_c  = req_wdata;
        end
    end

    // Reset kills the strobes combinationally so nothing reaches the RAM while held.
    assign ram_cen  = ram_cen_c | ~ram_rstn;
    assign ram_wen  = ram_wen_c | {2{~ram_rstn}};
    assign ram_addr = ram_addr_c;
    assign ram_din  = ram_din_c;

    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= ram_addr_c;
            din_q  <= ram_din_c;
        end
    end

    // ---------------------------------------------------------------- response buffer
    always_ff @(posedge ram_clk or negedge ram_rstn) begin
        if (!ram_rstn) begin
            rd_inflight_q <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
            fifo_mem[0]   <= '0;
            fifo_mem[1]   <= '0;
        end else begin
            rd_inflight_q <= rd_fire;
            if (push) begin
                fifo_mem[wr_ptr_q] <= ram_dout;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rsp_rdata = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_mpsoc_mpram_master.sv
// Directed bench for mpsoc_mpram_master with a behavioural single-port RAM model;
// the MPRAM_INIT_EN build additionally checks the power-up zero sweep.
module tb_mpsoc_mpram_master;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [1:0]    req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic          ram_cen;
    logic [1:0]    ram_wen;

    mpsoc_mpram_master #(.AW(AW), .DW(DW), .MEM_SIZE(256)) dut (
        .ram_clk   (clk),
        .ram_rstn  (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model: byte-masked write, read data on the cycle after the strobe
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!ram_cen) begin
            if (ram_wen == 2'b11) ram_dout <= mem[ram_addr];
            else begin
                if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
                if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_n = 0;
    logic [DW-1:0] rsp_q [$];
    int            rsp_cyc [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            rsp_q.push_back(rsp_rdata);
            rsp_cyc.push_back(cyc);
        end
        if (req_valid && req_ready) acc_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = a; req_wdata = wd;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    // drive a request and hold it until accepted (bounded)
    task automatic issue(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
        bit done = 1'b0;
        drive(we, be, a, wd);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = req_ready;
            step();
        end
        if (!done) chk("issue_timeout", 0, 1);
        idle();
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 50 && rsp_q.size() < n; i++) @(posedge clk);
        chk("rsp_count", rsp_q.size(), n);
        #1;
    endtask

    task automatic wait_run();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = req_ready;
        end
        if (!done) chk("run_timeout", 0, 1);
        step();
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00; req_addr = '0; req_wdata = '0;
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cen", ram_cen, 1);
        chk("rst_wen", ram_wen, 2'b11);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
`ifdef MPRAM_INIT_EN
        chk("rst_init_done", init_done, 0);
`else
        chk("rst_init_done", init_done, 1);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef MPRAM_INIT_EN
        begin
            int n = 0;
            bit fin = 1'b0;
            for (int i = 0; i < 200 && !fin; i++) begin
                @(negedge clk);
                if (init_done) fin = 1'b1;
                else begin
                    if (n == 0) begin
                        chk("init_first_addr", ram_addr, 0);
                        chk("init_cen", ram_cen, 0);
                        chk("init_wen", ram_wen, 2'b00);
                        chk("init_req_ready", req_ready, 0);
                    end
                    if (n == 63) chk("init_last_addr", ram_addr, 63);
                    n++;
                end
            end
            chk("init_len", n, 64);
        end
`else
        @(negedge clk);
        chk("boot_req_ready", req_ready, 0);
`endif
        wait_run();

        // full-word write then read-back, checking strobes and T+2 latency
        drive(1'b1, 2'b11, 6'd5, 16'hA55A);
        @(negedge clk);
        chk("wr_cen", ram_cen, 0);
        chk("wr_wen", ram_wen, 2'b00);
        chk("wr_addr", ram_addr, 5);
        chk("wr_din", ram_din, 16'hA55A);
        step();
        drive(1'b0, 2'b00, 6'd5, 16'h0);
        @(negedge clk);
        chk("rd_cen", ram_cen, 0);
        chk("rd_wen", ram_wen, 2'b11);
        step();
        idle();
        @(negedge clk);
        chk("rd_t1_valid", rsp_valid, 0);
        step();
        @(negedge clk);
        chk("rd_t2_valid", rsp_valid, 1);
        chk("rd_t2_data", rsp_rdata, 16'hA55A);
        step();
        rsp_q.delete(); rsp_cyc.delete();

        // partial-byte write merges with existing data
        issue(1'b1, 2'b11, 6'd9, 16'h1234);
        drive(1'b1, 2'b10, 6'd9, 16'hFF00);
        @(negedge clk);
        chk("be10_wen", ram_wen, 2'b01);
        step();
        issue(1'b0, 2'b00, 6'd9, 16'h0);
        @(negedge clk);
        chk("hold_addr", ram_addr, 9);
        chk("hold_din", ram_din, 16'hFF00);
        chk("hold_cen", ram_cen, 1);
        wait_rsp(1);
        chk("be10_data", rsp_q[0], 16'hFF34);
        rsp_q.delete(); rsp_cyc.delete();

        // back-to-back reads, one response per cycle
        for (int i = 0; i < 8; i++) issue(1'b1, 2'b11, AW'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b00, AW'(i), 16'h0);
            @(negedge clk);
            chk("b2b_ready", req_ready, 1);
            step();
        end
        idle();
        wait_rsp(8);
        for (int i = 0; i < 8; i++) chk("b2b_data", rsp_q[i], 16'h1000 + 16'(i));
        chk("b2b_span", rsp_cyc[7] - rsp_cyc[0], 7);
        rsp_q.delete(); rsp_cyc.delete();

        // backpressure: only two reads accepted while rsp_ready is low
        begin
            int acc0;
            rsp_ready = 1'b0;
            acc0 = acc_n;
            issue(1'b0, 2'b00, 6'd0, 16'h0);
            issue(1'b0, 2'b00, 6'd1, 16'h0);
            drive(1'b0, 2'b00, 6'd2, 16'h0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("bp_ready_low", req_ready, 0);
                step();
            end
            chk("bp_accepted", acc_n - acc0, 2);
            @(negedge clk);
            chk("bp_head_valid", rsp_valid, 1);
            chk("bp_head_data", rsp_rdata, 16'h1000);
            step();
            rsp_ready = 1'b1;
            issue(1'b0, 2'b00, 6'd2, 16'h0);
            issue(1'b0, 2'b00, 6'd3, 16'h0);
            wait_rsp(4);
            for (int i = 0; i < 4; i++) chk("bp_data", rsp_q[i], 16'h1000 + 16'(i));
            chk("bp_accepted_all", acc_n - acc0, 4);
        end
        rsp_q.delete(); rsp_cyc.delete();

        // write with no byte enables: consumed, no RAM access, no response
        drive(1'b1, 2'b00, 6'd20, 16'hBEEF);
        @(negedge clk);
        chk("be00_ready", req_ready, 1);
        chk("be00_cen", ram_cen, 1);
        chk("be00_wen", ram_wen, 2'b11);
        chk("be00_addr_hold", ram_addr, 3);
        chk("be00_din_hold", ram_din, 16'h1007);
        step();
        idle();
        repeat (3) step();
        chk("be00_no_rsp", rsp_q.size(), 0);

        // reset with two buffered responses
        rsp_ready = 1'b0;
        issue(1'b0, 2'b00, 6'd0, 16'h0);
        issue(1'b0, 2'b00, 6'd1, 16'h0);
        repeat (3) step();
        @(negedge clk);
        chk("prerst_valid", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_rdata", rsp_rdata, 0);
        chk("midrst_cen", ram_cen, 1);
        chk("midrst_ready", req_ready, 0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_run();
        repeat (3) step();
        chk("postrst_no_rsp", rsp_q.size(), 0);

`ifdef MPRAM_INIT_EN
        issue(1'b0, 2'b00, 6'd63, 16'h0);
        wait_rsp(1);
        chk("init_zero_63", rsp_q[0], 16'h0000);
`else
        issue(1'b0, 2'b00, 6'd0, 16'h0);
        wait_rsp(1);
        chk("postrst_read", rsp_q[0], 16'h1000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mpsoc_mpram_master.md
# mpsoc_mpram_master

Request-side controller for the single-port MPSoC RAM macro: converts a valid/ready request channel (read or byte-masked write) into the macro's active-low chip-enable/write-enable strobes. It also returns read data on a valid/ready response channel through a 2-entry buffer. The block sits between a bus/CPU port and the RAM instance. It sustains one access per cycle when the response consumer keeps up.

## Interface
Parameters:
- AW, 6, word address width.
- DW, 16, data width; must be 16 (two byte lanes).
- MEM_SIZE, 256, memory size in bytes; informational only, not used for addressing.

Ports:
- ram_clk  in  1  single clock for the block and the RAM.
- ram_rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  2  byte enables, active high; [0] selects the low byte, [1] the high byte; ignored on reads.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DW  read data.
- init_done  out  1  memory usable; requests accepted only while high.
- ram_addr  out  AW  to RAM.
- ram_din  out  DW  to RAM.
- ram_cen  out  1  RAM chip enable, active low.
- ram_wen  out  2  RAM byte write enables, active low.
- ram_dout  in  DW  from RAM; valid in the cycle after a read strobe.

## Operation
- States:
  - INIT exists only with the macro; see Configuration.
  - RUN is the normal operating state.
- Accept: the request is accepted when req_valid && req_ready, where req_ready = RUN && (pending < 2 || (rsp_valid && rsp_ready)).
  - pending counts reads in flight plus buffer entries; its range is 0..2.
- Accepted read: in the same cycle, the block drives ram_cen=0, ram_wen=2'b11, ram_addr=req_addr. pending increments.
- Accepted write with req_be != 0: in the same cycle, the block drives ram_cen=0, ram_wen=~req_be, ram_din=req_wdata. No response is generated.
- Accepted write with req_be == 0: the request is consumed, ram_cen stays 1, and there is no RAM access and no response.
- No accepted request: ram_cen=1, ram_wen=2'b11. ram_addr and ram_din hold their last values.
- Read capture: one cycle after the read strobe, ram_dout is written into the 2-entry FIFO.
- Response: rsp_valid = FIFO not empty; rsp_rdata = FIFO head. Responses are delivered in request order.
- Pop on rsp_valid && rsp_ready decrements pending. A pop and a new read acceptance in the same cycle leave pending unchanged.
- Read-after-write to the same address in consecutive cycles returns the new data; the RAM macro guarantees this.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - ram_cen=1, ram_wen=2'b11, ram_addr=0, ram_din=0.
  - pending=0, FIFO empty.
  - init_done=0 with the macro, 1 without it.
- The RAM strobes are combinational from the request in the acceptance cycle T.
- rsp_valid rises in cycle T+2 for a read accepted in T, provided the FIFO is empty.
- Throughput: 1 read per cycle while rsp_ready=1. When rsp_ready=0, at most 2 reads are accepted, then req_ready=0 until a pop.
- Reset asserted mid-operation:
  - In-flight reads and buffered responses are discarded.
  - The RAM strobes go inactive immediately (asynchronously).
  - No partial response is ever emitted.

## Configuration
- MPRAM_INIT_EN defined:
  - After reset release the block enters INIT and writes zero to addresses 0 .. 2**AW-1, one word per cycle, with ram_cen=0 and ram_wen=2'b00.
  - req_ready=0 during INIT.
  - init_done rises, and the state moves to RUN, in the cycle after the last address is written. This is cycle 2**AW after the first INIT cycle; 64 for the default AW.
  - A reset during INIT restarts the sweep at address 0.
- MPRAM_INIT_EN undefined:
  - There is no INIT state; RUN is entered on the first clock after reset release.
  - init_done is constant 1, and memory contents are undefined until written.

## Test plan
- Write 0xA55A to address 5 with be=2'b11, then read address 5, with rsp_ready=1 → ram_wen=2'b00 in the write cycle; rsp_rdata=0xA55A two cycles after the read is accepted.
- Fill with 0x1234 to address 9, then write 0xFF00 with be=2'b10 to address 9, then read it → response 0xFF34.
- Accept 8 back-to-back reads of addresses 0..7 with rsp_ready=1 → req_ready stays high, 8 responses in order, one per cycle.
- Hold rsp_ready=0 and issue 4 reads → exactly 2 accepted; req_ready=0. Then raise rsp_ready → remaining reads accepted, 4 responses delivered in order.
- Write with be=2'b00 → ram_cen stays 1 for the whole cycle; no rsp_valid. Assert ram_rstn=0 while 2 responses are buffered → rsp_valid=0 immediately; no stale data after reset release.
- With MPRAM_INIT_EN defined → init_done=0 and req_ready=0 for 64 cycles after reset, then init_done=1. A read of address 63 then returns 0x0000.
